// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter merging NUM_SLAVES
// AXI-Stream requesters onto one registered output stream.
//
// A requester is granted in IDLE and keeps the grant (LOCKED) until it
// transfers a beat with tlast; only then is the next requester chosen,
// searching upward from the one after the previous winner.
//
// Ports:
//   clk            - clock, rising edge
//   reset_n        - asynchronous active-low reset
//   s_axis_tvalid  - per-requester valid            [NUM_SLAVES]
//   s_axis_tdata   - requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tlast   - per-requester end of packet    [NUM_SLAVES]
//   s_axis_tready  - per-requester ready            [NUM_SLAVES]
//   m_axis_tvalid  - output valid (registered)
//   m_axis_tdata   - output data  (registered)
//   m_axis_tlast   - output end of packet (registered)
//   m_axis_tid     - index of the requester that sourced the output beat
//   m_axis_tready  - downstream ready
module axis_rr_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_SLAVES)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_SLAVES-1:0]            s_axis_tvalid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SLAVES-1:0]            s_axis_tlast,
  output logic [NUM_SLAVES-1:0]            s_axis_tready,
  output logic                             m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  input  logic                             m_axis_tready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;

  logic [ID_WIDTH-1:0]   rr_pick;
  logic                  rr_found;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  out_free;
  logic                  xfer;

  // Round-robin search: candidate k steps after last_grant, first hit wins.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SLAVES; k++) begin
      idx = (32'(last_grant_q) + k) % 32'(NUM_SLAVES);
      for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
        if (!rr_found && (j == idx) && s_axis_tvalid[j]) begin
          rr_found = 1'b1;
          rr_pick  = ID_WIDTH'(j);
        end
      end
    end
  end

  // Granted requester's signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign xfer     = (state_q == LOCKED) && out_free && sel_valid;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == LOCKED && out_free) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (grant_q == ID_WIDTH'(i)) s_axis_tready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = LOCKED;
          grant_d = rr_pick;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_SLAVES - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (xfer) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= grant_q;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a packet-level reference model.
module tb_axis_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            gap;
  } beat_t;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    logic          l;
  } obs_t;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b1;
  logic [NS-1:0]          s_axis_tvalid = '0;
  logic [NS-1:0][DW-1:0]  s_axis_tdata = '0;
  logic [NS-1:0]          s_axis_tlast = '0;
  logic [NS-1:0]          s_axis_tready;
  logic                   m_axis_tvalid;
  logic [DW-1:0]          m_axis_tdata;
  logic                   m_axis_tlast;
  logic [IW-1:0]          m_axis_tid;
  logic                   m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .NUM_SLAVES(NS),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tready(m_axis_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source side: per-requester beat queues and held valid flags.
  beat_t q [NS][$];
  bit    sv [NS];
  bit    acc [NS];
  obs_t  obs [$];
  int    mrdy_low = 0;
  bit    rand_rdy = 1'b0;

  // Reference model: current owner (-1 = none), previous winner, output slot.
  int            m_owner;
  int            m_last;
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_ol;
  int            m_oid;

  task automatic model_reset();
    m_owner = -1;
    m_last  = NS - 1;
    m_ov    = 1'b0;
    m_od    = '0;
    m_ol    = 1'b0;
    m_oid   = 0;
  endtask

  task automatic push_pkt(input int src, input logic [DW-1:0] base, input int len,
                          input int gap_at, input int gap_len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d   = base + DW'(k);
      b.l   = (k == len - 1);
      b.gap = (k == gap_at) ? gap_len : 0;
      q[src].push_back(b);
    end
  endtask

  task automatic step();
    logic [NS-1:0] exp_vec;
    bit            out_free;
    bit            xf;
    bit            found;
    beat_t         b;
    int            c;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        void'(q[i].pop_front());
        sv[i] = 1'b0;
      end
      if (!sv[i] && q[i].size() > 0) begin
        b = q[i][0];
        if (b.gap > 0) begin
          b.gap--;
          q[i][0] = b;
        end else begin
          sv[i] = 1'b1;
        end
      end
      s_axis_tvalid[i] = sv[i];
      if (sv[i]) begin
        s_axis_tdata[i] = q[i][0].d;
        s_axis_tlast[i] = q[i][0].l;
      end else begin
        s_axis_tdata[i] = '0;
        s_axis_tlast[i] = 1'b0;
      end
    end
    if (mrdy_low > 0) begin
      mrdy_low--;
      m_axis_tready = 1'b0;
    end else begin
      m_axis_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    out_free = !m_ov || m_axis_tready;
    exp_vec  = '0;
    if (m_owner >= 0 && out_free) exp_vec[m_owner] = 1'b1;
    check_eq("s_tready", 64'(s_axis_tready), 64'(exp_vec));
    check_eq("m_tvalid", 64'(m_axis_tvalid), 64'(m_ov));
    if (m_ov) begin
      check_eq("m_tdata", 64'(m_axis_tdata), 64'(m_od));
      check_eq("m_tid",   64'(m_axis_tid),   64'(m_oid));
      check_eq("m_tlast", 64'(m_axis_tlast), 64'(m_ol));
    end
    if (m_axis_tvalid && m_axis_tready)
      obs.push_back('{int'(m_axis_tid), m_axis_tdata, m_axis_tlast});
    for (int i = 0; i < NS; i++) acc[i] = sv[i] && s_axis_tready[i];

    xf = (m_owner >= 0) && sv[m_owner] && out_free;
    if (xf) begin
      m_od  = q[m_owner][0].d;
      m_ol  = q[m_owner][0].l;
      m_oid = m_owner;
      m_ov  = 1'b1;
      if (m_ol) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else begin
      if (m_axis_tready) m_ov = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          c = (m_last + k) % NS;
          if (!found && sv[c]) begin
            found   = 1'b1;
            m_owner = c;
          end
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_m_tdata",  64'(m_axis_tdata),  64'(0));
    check_eq("rst_m_tid",    64'(m_axis_tid),    64'(0));
    check_eq("rst_m_tlast",  64'(m_axis_tlast),  64'(0));
    check_eq("rst_s_tready", 64'(s_axis_tready), 64'(0));
    for (int i = 0; i < NS; i++) begin
      q[i].delete();
      sv[i]  = 1'b0;
      acc[i] = 1'b0;
    end
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    obs.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_obs(input string tag, input int idx, input int id,
                           input logic [DW-1:0] d, input bit l);
    logic [63:0] got;
    logic [63:0] exp;
    exp = (64'(id) << 40) | (64'(l) << 32) | 64'(d);
    if (idx < obs.size())
      got = (64'(obs[idx].id) << 40) | (64'(obs[idx].l) << 32) | 64'(obs[idx].d);
    else
      got = '1;
    check_eq(tag, got, exp);
  endtask

  initial begin
    int first;
    int pending;
    int len;
    beat_t b;

    do_reset();

    // All four ports, one-beat packets: order 0..3, first valid two clocks in.
    for (int i = 0; i < NS; i++) push_pkt(i, DW'('hA0 + i), 1, -1, 0);
    first = -1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (m_axis_tvalid && first < 0) first = s;
    end
    check_eq("first_latency", 64'(first), 64'(2));
    check_eq("rr_count", 64'(obs.size()), 64'(4));
    for (int i = 0; i < NS; i++) check_obs("rr_order", i, i, DW'('hA0 + i), 1'b1);

    // Port 2 four-beat packet, port 1 requesting one cycle later.
    obs.delete();
    push_pkt(2, 'h10, 4, -1, 0);
    push_pkt(1, 'h55, 1, 0, 1);
    run(14);
    check_eq("lock_count", 64'(obs.size()), 64'(5));
    for (int k = 0; k < 4; k++) check_obs("lock_p2", k, 2, DW'('h10 + k), (k == 3));
    check_obs("lock_p1", 4, 1, 'h55, 1'b1);

    // Downstream stall of three cycles mid-packet.
    obs.delete();
    push_pkt(0, 'h20, 4, -1, 0);
    run(3);
    mrdy_low = 3;
    run(12);
    check_eq("stall_count", 64'(obs.size()), 64'(4));
    for (int k = 0; k < 4; k++) check_obs("stall_beat", k, 0, DW'('h20 + k), (k == 3));

    // Port 3 gaps two cycles mid-packet while port 0 waits.
    obs.delete();
    push_pkt(3, 'h30, 4, 2, 2);
    push_pkt(0, 'h44, 1, -1, 0);
    run(16);
    check_eq("gap_count", 64'(obs.size()), 64'(5));
    for (int k = 0; k < 4; k++) check_obs("gap_p3", k, 3, DW'('h30 + k), (k == 3));
    check_obs("gap_p0", 4, 0, 'h44, 1'b1);

    // Reset while locked on port 1, then all ports request.
    obs.delete();
    push_pkt(1, 'h60, 3, -1, 0);
    run(3);
    do_reset();
    for (int i = 0; i < NS; i++) push_pkt(i, DW'('hB0 + i), 1, -1, 0);
    run(12);
    check_eq("post_rst_count", 64'(obs.size()), 64'(4));
    check_obs("post_rst_first", 0, 0, 'hB0, 1'b1);

    // Randomized traffic with random gaps and backpressure.
    rand_rdy = 1'b1;
    for (int s = 0; s < 3000; s++) begin
      if (s == 1500) do_reset();
      for (int i = 0; i < NS; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 5) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) begin
            b.d   = DW'($urandom);
            b.l   = (k == len - 1);
            b.gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            q[i].push_back(b);
          end
        end
      end
      step();
      if (obs.size() > 64) obs.delete();
    end

    // Drain with bounded budget.
    rand_rdy = 1'b0;
    pending  = 1;
    for (int s = 0; s < 300 && pending != 0; s++) begin
      step();
      pending = int'(m_axis_tvalid);
      for (int i = 0; i < NS; i++) pending += q[i].size();
    end
    check_eq("drain", 64'(pending), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 4, meaning the number of AXI-Stream requester ports (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning tdata width per port.
REQ-003 The block SHALL have parameter ID_WIDTH, default 2, meaning the m_axis_tid width, equal to clog2(NUM_SLAVES).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port s_axis_tvalid, input, NUM_SLAVES bits: per-requester valid.
REQ-007 The block SHALL have port s_axis_tdata, input, NUM_SLAVES*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port s_axis_tlast, input, NUM_SLAVES bits: per-requester end of packet.
REQ-009 The block SHALL have port s_axis_tready, output, NUM_SLAVES bits: per-requester ready.
REQ-010 The block SHALL have port m_axis_tvalid, output, 1 bit: shared output valid.
REQ-011 The block SHALL have port m_axis_tdata, output, DATA_WIDTH bits: shared output data.
REQ-012 The block SHALL have port m_axis_tlast, output, 1 bit: shared output end of packet.
REQ-013 The block SHALL have port m_axis_tid, output, ID_WIDTH bits: index of the requester that sourced the current beat.
REQ-014 The block SHALL have port m_axis_tready, input, 1 bit: downstream ready.

Function
REQ-015 The FSM SHALL have two states: IDLE (no grant) and LOCKED (one requester granted until its packet ends).
REQ-016 In IDLE with any s_axis_tvalid set, the block SHALL register a grant to the first set requester, searching upward from (last_grant+1) mod NUM_SLAVES with wrap, and enter LOCKED on the next edge.
REQ-017 In IDLE, s_axis_tready SHALL be all zeros; in LOCKED, only the granted bit SHALL be asserted, and only when the output register is empty or m_axis_tready=1.
REQ-018 An input beat SHALL transfer when s_axis_tvalid[g] and s_axis_tready[g] are both high; it SHALL be loaded into the output register with tdata, tlast and tid=g.
REQ-019 The output register SHALL assert m_axis_tvalid the cycle after the load and hold data, tlast and tid stable until m_axis_tready=1.
REQ-020 Simultaneous output drain and input load SHALL sustain one beat per clock with no bubble.
REQ-021 Accepting a beat with tlast=1 SHALL return the FSM to IDLE and set last_grant=g; no further beats from g SHALL be accepted in that cycle.
REQ-022 Latency from first s_axis_tvalid (in IDLE, output empty) to m_axis_tvalid SHALL be exactly 2 clocks: one arbitration, one register.
REQ-023 Deasserting s_axis_tvalid[g] mid-packet SHALL keep the grant (LOCKED); other requesters SHALL NOT be served until g sends tlast.
REQ-024 A single active requester SHALL be re-granted after each packet, with one IDLE cycle between packets.
REQ-025 Requests arriving while LOCKED SHALL be considered only at the next IDLE arbitration.
REQ-026 Input beats SHALL NOT be dropped, duplicated or reordered within a packet; packets from different requesters SHALL NOT interleave on m_axis.

Reset
REQ-027 While reset_n=0: FSM=IDLE, last_grant=NUM_SLAVES-1 (so requester 0 wins first), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, s_axis_tready=0.
REQ-028 Reset asserted mid-packet SHALL discard the pending beat and grant immediately (asynchronously); after release, arbitration SHALL restart from requester 0.

Verification
REQ-029 All 4 ports assert tvalid at once with 1-beat packets (tlast=1, data 0xA0+i), m_axis_tready=1 -> output tid order 0,1,2,3, data 0xA0..0xA3, first m_axis_tvalid 2 clocks after the request.
REQ-030 Port 2 sends a 4-beat packet 0x10..0x13 while port 1 requests -> all 4 beats of port 2 appear contiguously before any port 1 beat, and m_axis_tlast=1 only on 0x13.
REQ-031 m_axis_tready held low for 3 cycles mid-packet -> m_axis_tdata/tid/tlast stable, s_axis_tready low, no beat lost; 1 beat per clock resumes once ready=1.
REQ-032 Port 3 drops tvalid for 2 cycles mid-packet while port 0 requests -> grant stays on port 3 until its tlast, then port 0 is served.
REQ-033 reset_n pulsed low while LOCKED on port 1 -> outputs return to reset values immediately; after release with all ports requesting, port 0 is granted first.
